// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-byte I2C master. One request runs START, address+R/W,
// address ACK, one data byte (write, or read closed with a master NACK), STOP.
// SCL/SDA are open-drain: an *_oe of 1 pulls the line low, 0 releases it.
module i2c_master_byte #(
    parameter int QTR_DIV = 250
) (
    input  logic       iclk,
    input  logic       reset_n,
    input  logic       istart,
    input  logic       irw,
    input  logic [6:0] iaddr,
    input  logic [7:0] iwdata,
    input  logic       isda,
    output logic       oscl_oe,
    output logic       osda_oe,
    output logic       obusy,
    output logic       odone,
    output logic       oack_err,
    output logic [7:0] ordata
);
    localparam int CW = $clog2(QTR_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(QTR_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK,
        S_RDATA, S_RNACK, S_STOP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          err_q, err_d;
    logic [1:0]    sync_q;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    rdata_q, rdata_d;

    logic qtick;
    logic slot_end;
    logic sample;

    // qtick ends a quarter; a slot ends with q3; SDA is sampled as q3 begins
    assign qtick    = (qcnt_q == '0);
    assign slot_end = qtick && (quarter_q == 2'd3);
    assign sample   = qtick && (quarter_q == 2'd2);

    // Two-flop synchroniser for the SDA pad; idle bus reads high
    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], isda};
        end
    end

    // State and datapath registers; reset releases the bus immediately
    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            rx_q      <= 8'h00;
            wdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            err_q     <= err_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state logic; pad enables are derived from the next state/quarter so
    // the registered pins line up exactly with the slot timing
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    rw_d      = irw;
                    shift_d   = {iaddr, irw};
                    wdata_d   = iwdata;
                    err_d     = 1'b0;
                    qcnt_d    = RELOAD;
                    quarter_d = 2'd0;
                    bit_d     = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (qtick) begin
                    qcnt_d    = RELOAD;
                    quarter_d = quarter_q + 2'd1;
                end else begin
                    qcnt_d = qcnt_q - CW'(1);
                end
                if (sample) begin
                    if (state_q == S_AACK || state_q == S_WACK) begin
                        if (sync_q[1]) begin
                            err_d = 1'b1;
                        end
                    end else if (state_q == S_RDATA) begin
                        rx_d = {rx_q[6:0], sync_q[1]};
                    end
                end
                if (slot_end) begin
                    case (state_q)
                        S_START: begin
                            bit_d   = 3'd0;
                            state_d = S_ADDR;
                        end
                        S_ADDR: begin
                            if (bit_q == 3'd7) begin
                                state_d = S_AACK;
                            end else begin
                                bit_d   = bit_q + 3'd1;
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                        S_AACK: begin
                            if (err_q) begin
                                state_d = S_STOP;
                            end else begin
                                bit_d   = 3'd0;
                                shift_d = wdata_q;
                                state_d = rw_q ? S_RDATA : S_WDATA;
                            end
                        end
                        S_WDATA: begin
                            if (bit_q == 3'd7) begin
                                state_d = S_WACK;
                            end else begin
                                bit_d   = bit_q + 3'd1;
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                        S_RDATA: begin
                            if (bit_q == 3'd7) begin
                                state_d = S_RNACK;
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end
                        S_WACK, S_RNACK: begin
                            state_d = S_STOP;
                        end
                        S_STOP: begin
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            ack_err_d = err_q;
                            if (rw_q && !err_q) begin
                                rdata_d = rx_q;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    endcase
                end
            end
        endcase

        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_oe_d = (quarter_d == 2'd3);
                sda_oe_d = (quarter_d >= 2'd2);
            end
            S_ADDR, S_WDATA: begin
                scl_oe_d = ~quarter_d[1];
                sda_oe_d = ~shift_d[7];
            end
            S_AACK, S_WACK, S_RDATA, S_RNACK: begin
                scl_oe_d = ~quarter_d[1];
            end
            S_STOP: begin
                scl_oe_d = (quarter_d == 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    assign oscl_oe  = scl_oe_q;
    assign osda_oe  = sda_oe_q;
    assign obusy    = busy_q;
    assign odone    = done_q;
    assign oack_err = ack_err_q;
    assign ordata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// tb_i2c_master_byte: bench for the single-byte I2C master. A bus monitor
// decodes START/STOP and the bits on SCL rising edges; a slave model answers
// ACK/data on SCL falling edges. Results are compared with a transaction-level
// reference (slot counts, ack rules, last read byte).
module tb_i2c_master_byte;
    localparam int Q      = 4;
    localparam int BUDGET = 100 * Q + 20;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       present;
        logic       dack;
        logic [7:0] rdata;
        logic       exp_err;
        int         exp_lat;
        logic [7:0] exp_byte0;
        logic [7:0] exp_ordata;
    } vec_t;

    logic       iclk    = 1'b0;
    logic       reset_n = 1'b0;
    logic       istart  = 1'b0;
    logic       irw     = 1'b0;
    logic [6:0] iaddr   = 7'h00;
    logic [7:0] iwdata  = 8'h00;
    logic       isda;
    logic       oscl_oe, osda_oe, obusy, odone, oack_err;
    logic [7:0] ordata;

    logic       slave_sda  = 1'b1;
    logic       sl_present = 1'b1;
    logic       sl_dack    = 1'b1;
    logic [7:0] sl_rdata   = 8'h00;

    logic       mon_bits [0:63];
    int         mon_n     = 0;
    int         start_cnt = 0;
    int         stop_cnt  = 0;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_ordata = 8'h00;
    vec_t       vecs [5];
    int         txn_no = 0;

    assign isda = ~osda_oe & slave_sda;

    i2c_master_byte #(.QTR_DIV(Q)) dut (
        .iclk     (iclk),
        .reset_n  (reset_n),
        .istart   (istart),
        .irw      (irw),
        .iaddr    (iaddr),
        .iwdata   (iwdata),
        .isda     (isda),
        .oscl_oe  (oscl_oe),
        .osda_oe  (osda_oe),
        .obusy    (obusy),
        .odone    (odone),
        .oack_err (oack_err),
        .ordata   (ordata)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", name, txn_no, act, exp);
        end
    endtask

    // What the slave puts on SDA for bit position k (0..7 addr, 8 ack, 9..16 data, 17 ack)
    function automatic logic slave_bit(input int k);
        logic is_read;
        is_read = (k >= 8) ? mon_bits[7] : 1'b0;
        if (k == 8) return sl_present ? 1'b0 : 1'b1;
        if (!sl_present) return 1'b1;
        if (is_read && k >= 9 && k <= 16) return sl_rdata[16 - k];
        if (!is_read && k == 17) return sl_dack ? 1'b0 : 1'b1;
        return 1'b1;
    endfunction

    function automatic logic [7:0] assemble(input int base);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], mon_bits[base + i]};
        return b;
    endfunction

    // Transaction-level reference: slots per transaction, ack rules, read byte
    function automatic void model(inout vec_t v, inout logic [7:0] ord);
        int slots;
        v.exp_byte0 = {v.addr, v.rw};
        v.exp_err   = !v.present || (!v.rw && !v.dack);
        slots       = v.present ? (1 + 8 + 1 + 8 + 1 + 1) : (1 + 8 + 1 + 1);
        v.exp_lat   = slots * 4 * Q + 1;
        if (v.rw && v.present) ord = v.rdata;
        v.exp_ordata = ord;
    endfunction

    // Bus monitor and slave model
    initial begin
        logic prev_scl, prev_sda, cur_scl, cur_sda;
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        forever begin
            @(negedge iclk);
            cur_scl = ~oscl_oe;
            cur_sda = isda;
            if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                start_cnt++;
                mon_n     = 0;
                slave_sda = 1'b1;
            end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
                stop_cnt++;
            end else if (!prev_scl && cur_scl) begin
                if (mon_n < 64) mon_bits[mon_n] = cur_sda;
                mon_n++;
            end else if (prev_scl && !cur_scl) begin
                slave_sda = slave_bit(mon_n);
            end
            prev_scl = cur_scl;
            prev_sda = cur_sda;
        end
    end

    task automatic launch(input logic rw, input logic [6:0] addr, input logic [7:0] wdata);
        @(negedge iclk);
        irw       = rw;
        iaddr     = addr;
        iwdata    = wdata;
        istart    = 1'b1;
        start_cnt = 0;
        stop_cnt  = 0;
        @(posedge iclk);
    endtask

    // Called just after the accepting edge; cycle 1 is the period after that edge
    task automatic wait_done(input int poke_cyc, output int lat);
        lat = -1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge iclk);
            if (c == 1) begin
                istart = 1'b0;
                chk("busy_after_accept", 32'(obusy), 32'd1);
            end
            if (poke_cyc > 0 && c == poke_cyc) begin
                istart = 1'b1;
                irw    = ~irw;
                iaddr  = ~iaddr;
                iwdata = ~iwdata;
            end else if (poke_cyc > 0 && c == poke_cyc + 1) begin
                istart = 1'b0;
            end
            if (odone) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result(input vec_t v, input int lat);
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("ack_err", 32'(oack_err), 32'(v.exp_err));
        chk("ordata", 32'(ordata), 32'(v.exp_ordata));
        chk("start_count", 32'(start_cnt), 32'd1);
        chk("stop_count", 32'(stop_cnt), 32'd1);
        chk("scl_bits", 32'(mon_n), v.present ? 32'd19 : 32'd10);
        chk("addr_byte", 32'(assemble(0)), 32'(v.exp_byte0));
        chk("addr_ack_bit", 32'(mon_bits[8]), 32'(!v.present));
        if (v.present) begin
            chk("data_byte", 32'(assemble(9)), v.rw ? 32'(v.rdata) : 32'(v.wdata));
            chk("last_ack_bit", 32'(mon_bits[17]), v.rw ? 32'd1 : 32'(!v.dack));
        end
        $display("txn %0d rw=%0d addr=0x%02h wdata=0x%02h present=%0d dack=%0d lat=%0d ack_err=%0d ordata=0x%02h",
                 txn_no, v.rw, v.addr, v.wdata, v.present, v.dack, lat, oack_err, ordata);
        txn_no++;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        sl_present = v.present;
        sl_dack    = v.dack;
        sl_rdata   = v.rdata;
        launch(v.rw, v.addr, v.wdata);
        wait_done(0, lat);
        check_result(v, lat);
    endtask

    initial begin
        vec_t v;
        int   lat;
        int   ndone;

        vecs[0] = '{rw:1'b0, addr:7'h50, wdata:8'hA5, present:1'b1, dack:1'b1, rdata:8'h00,
                    exp_err:1'b0, exp_lat:321, exp_byte0:8'hA0, exp_ordata:8'h00};
        vecs[1] = '{rw:1'b1, addr:7'h3C, wdata:8'h00, present:1'b1, dack:1'b1, rdata:8'h96,
                    exp_err:1'b0, exp_lat:321, exp_byte0:8'h79, exp_ordata:8'h96};
        vecs[2] = '{rw:1'b0, addr:7'h50, wdata:8'h5A, present:1'b0, dack:1'b1, rdata:8'h00,
                    exp_err:1'b1, exp_lat:177, exp_byte0:8'hA0, exp_ordata:8'h96};
        vecs[3] = '{rw:1'b0, addr:7'h12, wdata:8'hC3, present:1'b1, dack:1'b0, rdata:8'h00,
                    exp_err:1'b1, exp_lat:321, exp_byte0:8'h24, exp_ordata:8'h96};
        vecs[4] = '{rw:1'b1, addr:7'h7F, wdata:8'h00, present:1'b0, dack:1'b1, rdata:8'h55,
                    exp_err:1'b1, exp_lat:177, exp_byte0:8'hFF, exp_ordata:8'h96};

        // Reset state
        repeat (3) @(negedge iclk);
        chk("rst_scl_oe", 32'(oscl_oe), 32'd0);
        chk("rst_sda_oe", 32'(osda_oe), 32'd0);
        chk("rst_busy", 32'(obusy), 32'd0);
        chk("rst_done", 32'(odone), 32'd0);
        chk("rst_ack_err", 32'(oack_err), 32'd0);
        chk("rst_ordata", 32'(ordata), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge iclk);

        // Directed table
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        exp_ordata = 8'h96;

        // istart mid-transaction and during DONE ignored; back-to-back start accepted
        v = '{rw:1'b0, addr:7'h2A, wdata:8'h3C, present:1'b1, dack:1'b1, rdata:8'h00,
              exp_err:1'b0, exp_lat:321, exp_byte0:8'h54, exp_ordata:8'h96};
        sl_present = 1'b1;
        sl_dack    = 1'b1;
        launch(v.rw, v.addr, v.wdata);
        wait_done(100, lat);
        check_result(v, lat);
        irw    = 1'b0;
        iaddr  = 7'h11;
        iwdata = 8'h81;
        istart = 1'b1;
        @(negedge iclk);
        chk("istart_in_done_ignored", 32'(obusy), 32'd0);
        chk("single_done_pulse", 32'(odone), 32'd0);
        start_cnt = 0;
        stop_cnt  = 0;
        @(posedge iclk);
        wait_done(0, lat);
        v = '{rw:1'b0, addr:7'h11, wdata:8'h81, present:1'b1, dack:1'b1, rdata:8'h00,
              exp_err:1'b0, exp_lat:321, exp_byte0:8'h22, exp_ordata:8'h96};
        check_result(v, lat);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge iclk);
            if (odone) ndone++;
        end
        chk("no_extra_done", 32'(ndone), 32'd0);

        // Asynchronous reset during the write data phase
        launch(1'b0, 7'h33, 8'hC3);
        for (int c = 1; c <= 200; c++) begin
            @(negedge iclk);
            if (c == 1) istart = 1'b0;
        end
        chk("pre_reset_scl_low", 32'(oscl_oe), 32'd1);
        chk("pre_reset_sda_low", 32'(osda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_scl", 32'(oscl_oe), 32'd0);
        chk("async_rst_sda", 32'(osda_oe), 32'd0);
        chk("async_rst_busy", 32'(obusy), 32'd0);
        repeat (3) @(negedge iclk);
        reset_n    = 1'b1;
        exp_ordata = 8'h00;
        repeat (2) @(negedge iclk);
        v = '{rw:1'b0, addr:7'h33, wdata:8'hC3, present:1'b1, dack:1'b1, rdata:8'h00,
              exp_err:1'b0, exp_lat:0, exp_byte0:8'h00, exp_ordata:8'h00};
        model(v, exp_ordata);
        run_vec(v);

        // Randomised transactions against the reference model
        for (int i = 0; i < 12; i++) begin
            v.rw      = 1'($urandom_range(0, 1));
            v.addr    = 7'($urandom);
            v.wdata   = 8'($urandom);
            v.present = ($urandom_range(0, 3) != 0);
            v.dack    = 1'($urandom_range(0, 1));
            v.rdata   = 8'($urandom);
            model(v, exp_ordata);
            run_vec(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
